// File: rtl/ram_sched.sv
// Two-requester scheduler (packet-decoder host and AES engine) for a single-port
// synchronous RAM. Round-robin arbitration with a bounded AES lock for key/state bursts.
module ram_sched #(
    parameter int LOCK_MAX = 16,
    parameter int AW       = 7,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    input  logic          aes_req,
    input  logic          aes_we,
    input  logic [AW-1:0] aes_addr,
    input  logic [DW-1:0] aes_wdata,
    input  logic          aes_lock,
    output logic          aes_ack,
    output logic          aes_rvalid,
    output logic [DW-1:0] aes_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    localparam int LCW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic            last_aes_reg, last_aes_next;
    logic [LCW-1:0]  lock_cnt_reg, lock_cnt_next;
    logic            sel_aes_reg, sel_aes_next;
    logic            ram_en_reg, ram_en_next;
    logic            ram_we_reg, ram_we_next;
    logic [AW-1:0]   ram_addr_reg, ram_addr_next;
    logic [DW-1:0]   ram_wdata_reg, ram_wdata_next;
    logic            busy_reg, busy_next;

    logic            grant;
    logic            grant_aes;
    logic            grant_host;
    logic            aes_keep;
    logic            capture;
    logic            win_we;
    logic [1:0]      grant_vec;

    // AES keeps the RAM only while it was the last winner, asks for the lock,
    // and has not yet used up its burst allowance.
    assign aes_keep   = last_aes_reg && aes_lock && (lock_cnt_reg < LCW'(LOCK_MAX));
    assign grant      = (state_reg == IDLE) && (host_req || aes_req);
    assign grant_aes  = grant && aes_req && (!host_req || aes_keep || !last_aes_reg);
    assign grant_host = grant && host_req && !grant_aes;
    assign grant_vec  = {grant_aes, grant_host};
    assign win_we     = grant_aes ? aes_we : host_we;
    assign capture    = (state_reg == CAPTURE);

    // State and shared datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            last_aes_reg  <= 1'b1;
            lock_cnt_reg  <= '0;
            sel_aes_reg   <= 1'b0;
            ram_en_reg    <= 1'b0;
            ram_we_reg    <= 1'b0;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_aes_reg  <= last_aes_next;
            lock_cnt_reg  <= lock_cnt_next;
            sel_aes_reg   <= sel_aes_next;
            ram_en_reg    <= ram_en_next;
            ram_we_reg    <= ram_we_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            busy_reg      <= busy_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = ISSUE;
            ISSUE:   state_next = ram_we_reg ? IDLE : CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for the registered outputs and arbitration history
    always_comb begin
        last_aes_next  = last_aes_reg;
        lock_cnt_next  = lock_cnt_reg;
        sel_aes_next   = sel_aes_reg;
        ram_en_next    = 1'b0;
        ram_we_next    = 1'b0;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        busy_next      = (state_next != IDLE);
        if (grant) begin
            ram_en_next    = 1'b1;
            ram_we_next    = win_we;
            ram_addr_next  = grant_aes ? aes_addr  : host_addr;
            ram_wdata_next = grant_aes ? aes_wdata : host_wdata;
            sel_aes_next   = grant_aes;
            last_aes_next  = grant_aes;
            if (grant_aes && aes_lock) begin
                if (lock_cnt_reg != LCW'(LOCK_MAX))
                    lock_cnt_next = lock_cnt_reg + LCW'(1);
            end else begin
                lock_cnt_next = '0;
            end
        end
    end

    // Per-requester return path: index 0 is the host, index 1 is AES.
    logic [1:0]    ack_vec;
    logic [1:0]    rvalid_vec;
    logic [DW-1:0] rdata_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic IS_AES = (gi == 1);
            logic          ack_reg;
            logic          rvalid_reg;
            logic [DW-1:0] rdata_reg;
            logic          mine;

            assign mine = capture && (sel_aes_reg == IS_AES);

            always_ff @(posedge clk) begin
                if (!rst) begin
                    ack_reg    <= 1'b0;
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    ack_reg    <= grant_vec[gi];
                    rvalid_reg <= mine;
                    if (mine)
                        rdata_reg <= ram_rdata;
                end
            end

            assign ack_vec[gi]    = ack_reg;
            assign rvalid_vec[gi] = rvalid_reg;
            assign rdata_arr[gi]  = rdata_reg;
        end
    endgenerate

    assign host_ack    = ack_vec[0];
    assign aes_ack     = ack_vec[1];
    assign host_rvalid = rvalid_vec[0];
    assign aes_rvalid  = rvalid_vec[1];
    assign host_rdata  = rdata_arr[0];
    assign aes_rdata   = rdata_arr[1];
    assign ram_en      = ram_en_reg;
    assign ram_we      = ram_we_reg;
    assign ram_addr    = ram_addr_reg;
    assign ram_wdata   = ram_wdata_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_ram_sched.sv
// Directed bench for ram_sched: reset values, host/AES access timing, arbitration
// order, AES lock bound, reset abort and dropped requests, against a 128x32 RAM model.
module tb_ram_sched;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack, host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          aes_req, aes_we, aes_lock;
    logic [AW-1:0] aes_addr;
    logic [DW-1:0] aes_wdata;
    logic          aes_ack, aes_rvalid;
    logic [DW-1:0] aes_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] mem [128];
    byte           grants [64];
    int            gcnt;
    int            both;
    int            hcnt;
    int            acnt;

    ram_sched #(.LOCK_MAX(16), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .aes_req(aes_req), .aes_we(aes_we), .aes_addr(aes_addr), .aes_wdata(aes_wdata),
        .aes_lock(aes_lock), .aes_ack(aes_ack), .aes_rvalid(aes_rvalid), .aes_rdata(aes_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles with requests as currently driven, logging each ack.
    task automatic run_grants(input int n);
        gcnt = 0;
        both = 0;
        repeat (n) begin
            tick();
            if (host_ack && aes_ack) both++;
            if (gcnt < 64) begin
                if (host_ack) begin grants[gcnt] = "H"; gcnt++; end
                else if (aes_ack) begin grants[gcnt] = "A"; gcnt++; end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[127] = 32'h1234_5678;
        ram_rdata = '0;
        rst = 1'b0;
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        aes_req = 0; aes_we = 0; aes_addr = '0; aes_wdata = '0; aes_lock = 0;
        repeat (3) tick();

        // Reset values
        check("rst_busy", busy, 0);
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_acks", {host_ack, aes_ack}, 0);
        check("rst_rvalids", {host_rvalid, aes_rvalid}, 0);
        check("rst_rdata", {host_rdata, aes_rdata}, 0);
        rst = 1'b1;

        // Host write 0x05 <= DEADBEEF
        host_req = 1; host_we = 1; host_addr = 7'h05; host_wdata = 32'hDEAD_BEEF;
        tick();
        check("hw_ack", {host_ack, aes_ack}, 2'b10);
        check("hw_en_we", {ram_en, ram_we}, 2'b11);
        check("hw_addr", ram_addr, 7'h05);
        check("hw_wdata", ram_wdata, 32'hDEAD_BEEF);
        check("hw_busy", busy, 1);
        host_req = 0;
        tick();
        check("hw_done_en_we", {ram_en, ram_we, host_ack}, 0);
        check("hw_done_busy", busy, 0);
        check("hw_addr_hold", ram_addr, 7'h05);

        // Host read 0x05, issued in the cycle right after the write
        host_req = 1; host_we = 0; host_addr = 7'h05; host_wdata = 32'h0;
        tick();
        check("hr_ack", host_ack, 1);
        check("hr_en_we", {ram_en, ram_we}, 2'b10);
        host_req = 0;
        tick();
        check("hr_n2_busy", busy, 1);
        check("hr_n2_rvalid", host_rvalid, 0);
        check("hr_n2_en", ram_en, 0);
        tick();
        check("hr_n3_rvalid", {host_rvalid, aes_rvalid}, 2'b10);
        check("hr_n3_rdata", host_rdata, 32'hDEAD_BEEF);
        check("hr_n3_busy", busy, 0);
        tick();
        check("hr_n4_rvalid", host_rvalid, 0);
        check("hr_rdata_hold", host_rdata, 32'hDEAD_BEEF);

        // AES read 0x7F with host idle
        aes_req = 1; aes_we = 0; aes_addr = 7'h7F;
        tick();
        check("ar_ack", {host_ack, aes_ack}, 2'b01);
        check("ar_addr", ram_addr, 7'h7F);
        aes_req = 0;
        tick();
        check("ar_n2_rvalid", {host_rvalid, aes_rvalid}, 0);
        tick();
        check("ar_n3_rvalid", {host_rvalid, aes_rvalid}, 2'b01);
        check("ar_n3_rdata", aes_rdata, 32'h1234_5678);
        check("ar_host_rdata_hold", host_rdata, 32'hDEAD_BEEF);
        tick();

        // Round-robin from reset, both requesters writing, no lock
        rst = 0; tick(); rst = 1;
        host_req = 1; host_we = 1; host_addr = 7'h10; host_wdata = 32'h1111_0000;
        aes_req = 1; aes_we = 1; aes_addr = 7'h11; aes_wdata = 32'h2222_0000; aes_lock = 0;
        run_grants(8);
        check("rr_count", gcnt, 4);
        check("rr_both", both, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant%0d", i), grants[i], (i % 2 == 0) ? "H" : "A");
        host_req = 0; aes_req = 0;
        tick();

        // AES lock burst: 16 AES grants, then host, then AES again
        rst = 0; tick(); rst = 1;
        host_req = 1; aes_req = 1; aes_lock = 1;
        run_grants(36);
        check("lock_count", gcnt, 18);
        check("lock_both", both, 0);
        for (int i = 0; i < 18; i++)
            check($sformatf("lock_grant%0d", i), grants[i], (i == 16) ? "H" : "A");
        host_req = 0; aes_req = 0; aes_lock = 0;
        tick();

        // Reset during CAPTURE of a host read aborts it
        host_req = 1; host_we = 0; host_addr = 7'h05;
        tick();
        check("ab_ack", host_ack, 1);
        host_req = 0;
        tick();
        check("ab_capture_busy", busy, 1);
        rst = 0;
        tick();
        check("ab_busy", busy, 0);
        check("ab_rvalid", host_rvalid, 0);
        check("ab_rdata_cleared", host_rdata, 0);
        rst = 1;
        tick();
        check("ab_rvalid_after", {host_rvalid, aes_rvalid}, 0);
        check("ab_idle", {busy, ram_en}, 0);

        // Host request withdrawn while AES holds the RAM under lock
        aes_req = 1; aes_we = 1; aes_lock = 1; aes_addr = 7'h20; aes_wdata = 32'hA0A0_0001;
        host_req = 1; host_we = 1; host_addr = 7'h21; host_wdata = 32'hBAD0_BAD0;
        hcnt = 0; acnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) host_req = 0;
            if (host_ack) hcnt++;
            if (aes_ack) acnt++;
        end
        aes_req = 0; aes_lock = 0;
        tick();
        tick();
        check("drop_host_acks", hcnt, 0);
        check("drop_aes_acks", acnt, 5);
        check("drop_aes_mem", mem[7'h20], 32'hA0A0_0001);
        check("drop_host_mem", mem[7'h21], 32'hC0DE_0021);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
